// File: rtl/frame_rr_arb_pkg.sv
// frame_arb_pkg: shared state type, frame field position and id-width helper for frame_rr_arb
package frame_arb_pkg;
  typedef enum logic {ARB, HOLD} state_e;
  // rw_flag sits this many bits below the frame MSB+1
  localparam int RW_FROM_TOP = 3;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/frame_rr_arb_if.sv
// frame_rr_arb_if: requester-side frame/read-data bus and array-side frame/read-return bus
interface frame_rr_arb_if #(
  parameter int NUM_PORTS       = 4,
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_FRAME_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3
);
  logic [NUM_PORTS*AXI_FRAME_WIDTH-1:0] in_frame_data;
  logic [NUM_PORTS-1:0]                 in_frame_valid;
  logic [NUM_PORTS-1:0]                 in_frame_ready;
  logic [AXI_DATA_WIDTH-1:0]            in_rdata;
  logic [NUM_PORTS-1:0]                 in_rvalid;
  logic [AXI_FRAME_WIDTH-1:0]           axi_frame_data;
  logic                                 axi_frame_valid;
  logic                                 axi_frame_ready;
  logic [AXI_DATA_WIDTH-1:0]            array_rdata;
  logic                                 array_rvalid;
  // arbiter side
  modport slave (
    input  in_frame_data, in_frame_valid, axi_frame_ready, array_rdata, array_rvalid,
    output in_frame_ready, in_rdata, in_rvalid, axi_frame_data, axi_frame_valid
  );
  // requester / array environment side
  modport master (
    output in_frame_data, in_frame_valid, axi_frame_ready, array_rdata, array_rvalid,
    input  in_frame_ready, in_rdata, in_rvalid, axi_frame_data, axi_frame_valid
  );
endinterface

// File: rtl/frame_rr_arb_fifo.sv
// rd_order_fifo: records the port id of each accepted read so returns can be steered in order
module rd_order_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  // a pop frees the slot the simultaneous push needs, so push is allowed at full when popping
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  // storage, no reset needed since pointers/count define validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  // pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= inc(wr_q);
      if (do_pop) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/frame_rr_arb.sv
// frame_rr_arb: round-robin arbiter of NUM_PORTS frame sources onto one array frame channel;
// define FRAME_ARB_WR_PRIO_EN to give eligible writes strict priority over reads.
module frame_rr_arb
  import frame_arb_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_FRAME_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3,
  parameter int RD_DEPTH        = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mc_en,
  frame_rr_arb_if.slave                     bus,
  output logic [id_width(NUM_PORTS)-1:0]    grant_id,
  output logic                              busy,
  output logic                              err_orphan_rd
);
  localparam int IDW = id_width(NUM_PORTS);
  localparam int FW  = AXI_FRAME_WIDTH;
  localparam int RWB = FW - RW_FROM_TOP;
  localparam int CW  = ((RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1) + 1;
  state_e               state_q, state_d;
  logic [IDW-1:0]       grant_q, grant_d, last_q, last_d;
  logic                 err_q;
  logic [NUM_PORTS-1:0] is_wr, elig, cand, ready;
  logic                 g_valid, push, pop, fifo_full, fifo_empty;
  logic [FW-1:0]        g_frame;
  logic [IDW-1:0]       head;
  logic [CW-1:0]        count;
  // first requesting port strictly after last, wrapping modulo NUM_PORTS
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req, input logic [IDW-1:0] last);
    logic [IDW-1:0] pick;
    pick = last;
    for (int i = NUM_PORTS; i >= 1; i--)
      if (req[(int'(last) + i) % NUM_PORTS]) pick = IDW'((int'(last) + i) % NUM_PORTS);
    return pick;
  endfunction
  // per-port rw flag; reads become ineligible while the order FIFO is full
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) is_wr[p] = bus.in_frame_data[p*FW + RWB];
  end
  assign elig = bus.in_frame_valid & (is_wr | {NUM_PORTS{!fifo_full}});
`ifdef FRAME_ARB_WR_PRIO_EN
  assign cand = |(elig & is_wr) ? (elig & is_wr) : elig;
`else
  assign cand = elig;
`endif
  assign g_valid = bus.in_frame_valid[grant_q];
  assign g_frame = bus.in_frame_data[grant_q*FW +: FW];
  // grant selection in ARB, frame forwarding and handshake tracking in HOLD
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    push    = 1'b0;
    ready   = '0;
    if (state_q == ARB) begin
      if (mc_en && |cand) begin
        grant_d = rr_pick(cand, last_q);
        state_d = HOLD;
      end
    end else begin
      ready[grant_q] = bus.axi_frame_ready;
      if (g_valid && bus.axi_frame_ready) begin
        last_d  = grant_q;
        push    = !g_frame[RWB];
        state_d = ARB;
      end else if (!g_valid) begin
        state_d = ARB;
      end
    end
  end
  // state, grant, round-robin pointer and sticky orphan flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      grant_q <= '0;
      last_q  <= IDW'(NUM_PORTS - 1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      err_q   <= err_q | (bus.array_rvalid & fifo_empty);
    end
  end
  assign pop                 = bus.array_rvalid;
  assign bus.in_frame_ready  = ready;
  assign bus.axi_frame_valid = (state_q == HOLD) && g_valid;
  assign bus.axi_frame_data  = (state_q == HOLD) ? g_frame : '0;
  assign bus.in_rdata        = bus.array_rdata;
  assign bus.in_rvalid       = (bus.array_rvalid && !fifo_empty) ? (NUM_PORTS'(1) << head) : '0;
  assign grant_id            = grant_q;
  assign busy                = (state_q == HOLD) || (count != '0);
  assign err_orphan_rd       = err_q;
  rd_order_fifo #(.DEPTH(RD_DEPTH), .W(IDW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (grant_q),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );
endmodule

// File: tb/tb_frame_rr_arb.sv
// tb_frame_rr_arb: directed scenarios for frame_rr_arb with hand-computed expectations
module tb_frame_rr_arb;
  localparam int NP = 4;
  localparam int AW = 20;
  localparam int DW = 64;
  localparam int FW = AW + DW + 3;
`ifdef FRAME_ARB_WR_PRIO_EN
  localparam int EXP_PRIO = 3;
`else
  localparam int EXP_PRIO = 1;
`endif
  logic clk = 1'b0;
  logic rst, mc_en, busy, err_orphan_rd;
  logic [1:0] grant_id;
  int n_chk = 0;
  int n_pass = 0;
  frame_rr_arb_if #(.NUM_PORTS(NP), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();
  frame_rr_arb #(.NUM_PORTS(NP), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .RD_DEPTH(4)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .mc_en         (mc_en),
    .bus           (bus.slave),
    .grant_id      (grant_id),
    .busy          (busy),
    .err_orphan_rd (err_orphan_rd)
  );
  always #5 clk = ~clk;
  function automatic logic [FW-1:0] fr(input int p, input bit rw, input logic [DW-1:0] d);
    return {2'b00, rw, AW'(p + 16), d};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int p, input bit rw, input bit v, input logic [DW-1:0] d);
    bus.in_frame_data[p*FW +: FW] = v ? fr(p, rw, d) : '0;
    bus.in_frame_valid[p] = v;
  endtask
  task automatic issue_read(input int p, input logic [DW-1:0] d);
    drive(p, 1'b0, 1'b1, d);
    bus.axi_frame_ready = 1'b1;
    tick();
    n_chk++; if (grant_id !== 2'(p)) $display("FAIL rd_grant: got %0d exp %0d", grant_id, p); else n_pass++;
    n_chk++; if (bus.in_frame_ready !== 4'(1 << p)) $display("FAIL rd_ready: got %b exp %b", bus.in_frame_ready, 4'(1 << p)); else n_pass++;
    tick();
    drive(p, 1'b0, 1'b0, '0);
  endtask
  task automatic test_reset();
    repeat (2) tick();
    n_chk++; if (bus.in_frame_ready !== 4'b0) $display("FAIL rst_ready: got %b exp 0000", bus.in_frame_ready); else n_pass++;
    n_chk++; if (bus.in_rvalid !== 4'b0) $display("FAIL rst_rvalid: got %b exp 0000", bus.in_rvalid); else n_pass++;
    n_chk++; if (bus.in_rdata !== 64'h0) $display("FAIL rst_rdata: got %h exp 0", bus.in_rdata); else n_pass++;
    n_chk++; if (bus.axi_frame_valid !== 1'b0) $display("FAIL rst_axi_valid: got %b exp 0", bus.axi_frame_valid); else n_pass++;
    n_chk++; if (bus.axi_frame_data !== '0) $display("FAIL rst_axi_data: got %h exp 0", bus.axi_frame_data); else n_pass++;
    n_chk++; if (grant_id !== 2'd0) $display("FAIL rst_grant: got %0d exp 0", grant_id); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
    n_chk++; if (err_orphan_rd !== 1'b0) $display("FAIL rst_err: got %b exp 0", err_orphan_rd); else n_pass++;
    rst = 1'b0;
    tick();
  endtask
  task automatic test_rr_writes();
    bus.axi_frame_ready = 1'b1;
    for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b1, 64'h1000 + 64'(p));
    for (int k = 0; k < 5; k++) begin
      tick();
      n_chk++; if (grant_id !== 2'(k % 4)) $display("FAIL rr_grant: got %0d exp %0d", grant_id, k % 4); else n_pass++;
      n_chk++; if (bus.axi_frame_valid !== 1'b1) $display("FAIL rr_valid: got %b exp 1", bus.axi_frame_valid); else n_pass++;
      n_chk++; if (bus.axi_frame_data !== fr(k % 4, 1'b1, 64'h1000 + 64'(k % 4))) $display("FAIL rr_data: got %h exp %h", bus.axi_frame_data, fr(k % 4, 1'b1, 64'h1000 + 64'(k % 4))); else n_pass++;
      n_chk++; if (bus.in_frame_ready !== 4'(1 << (k % 4))) $display("FAIL rr_ready: got %b exp %b", bus.in_frame_ready, 4'(1 << (k % 4))); else n_pass++;
      tick();
      n_chk++; if (bus.axi_frame_valid !== 1'b0) $display("FAIL rr_gap: got %b exp 0", bus.axi_frame_valid); else n_pass++;
    end
    for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b0, '0);
  endtask
  task automatic test_hold_stall();
    bus.axi_frame_ready = 1'b0;
    drive(2, 1'b0, 1'b1, 64'h2222);
    tick();
    n_chk++; if (grant_id !== 2'd2) $display("FAIL stall_grant: got %0d exp 2", grant_id); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (bus.axi_frame_valid !== 1'b1 || bus.in_frame_ready !== 4'b0) $display("FAIL stall_hold: got valid %b ready %b exp 1 0000", bus.axi_frame_valid, bus.in_frame_ready); else n_pass++;
      n_chk++; if (bus.axi_frame_data !== fr(2, 1'b0, 64'h2222)) $display("FAIL stall_data: got %h exp %h", bus.axi_frame_data, fr(2, 1'b0, 64'h2222)); else n_pass++;
      tick();
    end
    bus.axi_frame_ready = 1'b1;
    #1;
    n_chk++; if (bus.in_frame_ready !== 4'b0100) $display("FAIL stall_ready: got %b exp 0100", bus.in_frame_ready); else n_pass++;
    tick();
    drive(2, 1'b0, 1'b0, '0);
    n_chk++; if (bus.axi_frame_valid !== 1'b0) $display("FAIL stall_done: got %b exp 0", bus.axi_frame_valid); else n_pass++;
    n_chk++; if (u_dut.u_fifo.count_o !== 3'd1) $display("FAIL stall_count: got %0d exp 1", u_dut.u_fifo.count_o); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL stall_busy: got %b exp 1", busy); else n_pass++;
    bus.array_rdata = 64'hD2;
    bus.array_rvalid = 1'b1;
    #1;
    n_chk++; if (bus.in_rvalid !== 4'b0100 || bus.in_rdata !== 64'hD2) $display("FAIL stall_ret: got %b %h exp 0100 d2", bus.in_rvalid, bus.in_rdata); else n_pass++;
    tick();
    bus.array_rvalid = 1'b0;
    n_chk++; if (busy !== 1'b0) $display("FAIL stall_idle: got %b exp 0", busy); else n_pass++;
  endtask
  task automatic test_read_order();
    int ord[4] = '{1, 3, 0, 2};
    for (int k = 0; k < 4; k++) issue_read(ord[k], 64'h500 + 64'(k));
    n_chk++; if (u_dut.u_fifo.count_o !== 3'd4) $display("FAIL ord_count: got %0d exp 4", u_dut.u_fifo.count_o); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      bus.array_rdata = 64'hB0 + 64'(k);
      bus.array_rvalid = 1'b1;
      #1;
      n_chk++; if (bus.in_rvalid !== 4'(1 << ord[k])) $display("FAIL ord_rvalid: got %b exp %b", bus.in_rvalid, 4'(1 << ord[k])); else n_pass++;
      n_chk++; if (bus.in_rdata !== 64'hB0 + 64'(k)) $display("FAIL ord_rdata: got %h exp %h", bus.in_rdata, 64'hB0 + 64'(k)); else n_pass++;
      tick();
      bus.array_rvalid = 1'b0;
    end
  endtask
  task automatic test_full_mask();
    int ord[4] = '{0, 1, 2, 0};
    for (int p = 3; p < 7; p++) issue_read(p % 4, 64'h600 + 64'(p));
    drive(0, 1'b0, 1'b1, 64'hC0);
    drive(1, 1'b1, 1'b1, 64'hC1);
    tick();
    n_chk++; if (grant_id !== 2'd1) $display("FAIL full_grant: got %0d exp 1", grant_id); else n_pass++;
    n_chk++; if (bus.axi_frame_data !== fr(1, 1'b1, 64'hC1)) $display("FAIL full_data: got %h exp %h", bus.axi_frame_data, fr(1, 1'b1, 64'hC1)); else n_pass++;
    tick();
    drive(1, 1'b1, 1'b0, '0);
    tick();
    n_chk++; if (bus.axi_frame_valid !== 1'b0 || bus.in_frame_ready !== 4'b0) $display("FAIL full_masked: got %b %b exp 0 0000", bus.axi_frame_valid, bus.in_frame_ready); else n_pass++;
    bus.array_rdata = 64'hE0;
    bus.array_rvalid = 1'b1;
    #1;
    n_chk++; if (bus.in_rvalid !== 4'b1000) $display("FAIL full_pop: got %b exp 1000", bus.in_rvalid); else n_pass++;
    tick();
    bus.array_rvalid = 1'b0;
    n_chk++; if (bus.axi_frame_valid !== 1'b0) $display("FAIL full_still: got %b exp 0", bus.axi_frame_valid); else n_pass++;
    tick();
    n_chk++; if (grant_id !== 2'd0 || bus.axi_frame_valid !== 1'b1) $display("FAIL full_after_pop: got %0d %b exp 0 1", grant_id, bus.axi_frame_valid); else n_pass++;
    tick();
    drive(0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      bus.array_rdata = 64'hF0 + 64'(k);
      bus.array_rvalid = 1'b1;
      #1;
      n_chk++; if (bus.in_rvalid !== 4'(1 << ord[k])) $display("FAIL full_drain: got %b exp %b", bus.in_rvalid, 4'(1 << ord[k])); else n_pass++;
      tick();
      bus.array_rvalid = 1'b0;
    end
  endtask
  task automatic test_orphan();
    bus.array_rdata = 64'hFF;
    bus.array_rvalid = 1'b1;
    #1;
    n_chk++; if (bus.in_rvalid !== 4'b0) $display("FAIL orph_rvalid: got %b exp 0000", bus.in_rvalid); else n_pass++;
    n_chk++; if (err_orphan_rd !== 1'b0) $display("FAIL orph_early: got %b exp 0", err_orphan_rd); else n_pass++;
    tick();
    bus.array_rvalid = 1'b0;
    n_chk++; if (err_orphan_rd !== 1'b1) $display("FAIL orph_set: got %b exp 1", err_orphan_rd); else n_pass++;
    tick();
    n_chk++; if (err_orphan_rd !== 1'b1) $display("FAIL orph_sticky: got %b exp 1", err_orphan_rd); else n_pass++;
  endtask
  task automatic test_reset_mid_hold();
    bus.axi_frame_ready = 1'b0;
    drive(3, 1'b1, 1'b1, 64'h33);
    tick();
    n_chk++; if (grant_id !== 2'd3) $display("FAIL mrst_grant: got %0d exp 3", grant_id); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if (bus.axi_frame_valid !== 1'b0 || bus.axi_frame_data !== '0) $display("FAIL mrst_axi: got %b %h exp 0 0", bus.axi_frame_valid, bus.axi_frame_data); else n_pass++;
    n_chk++; if (grant_id !== 2'd0 || busy !== 1'b0) $display("FAIL mrst_grant_busy: got %0d %b exp 0 0", grant_id, busy); else n_pass++;
    n_chk++; if (err_orphan_rd !== 1'b0) $display("FAIL mrst_err: got %b exp 0", err_orphan_rd); else n_pass++;
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, 64'h30);
    bus.axi_frame_ready = 1'b1;
    tick();
    n_chk++; if (grant_id !== 2'd0) $display("FAIL mrst_next: got %0d exp 0", grant_id); else n_pass++;
    tick();
    drive(0, 1'b1, 1'b0, '0);
    drive(3, 1'b1, 1'b0, '0);
  endtask
  task automatic test_mc_en();
    mc_en = 1'b0;
    bus.axi_frame_ready = 1'b0;
    drive(1, 1'b1, 1'b1, 64'h11);
    tick();
    tick();
    n_chk++; if (bus.axi_frame_valid !== 1'b0) $display("FAIL en_off: got %b exp 0", bus.axi_frame_valid); else n_pass++;
    mc_en = 1'b1;
    tick();
    n_chk++; if (grant_id !== 2'd1 || bus.axi_frame_valid !== 1'b1) $display("FAIL en_grant: got %0d %b exp 1 1", grant_id, bus.axi_frame_valid); else n_pass++;
    mc_en = 1'b0;
    tick();
    n_chk++; if (bus.axi_frame_valid !== 1'b1) $display("FAIL en_hold: got %b exp 1", bus.axi_frame_valid); else n_pass++;
    bus.axi_frame_ready = 1'b1;
    #1;
    n_chk++; if (bus.in_frame_ready !== 4'b0010) $display("FAIL en_ready: got %b exp 0010", bus.in_frame_ready); else n_pass++;
    tick();
    tick();
    n_chk++; if (bus.axi_frame_valid !== 1'b0) $display("FAIL en_nogrant: got %b exp 0", bus.axi_frame_valid); else n_pass++;
    drive(1, 1'b1, 1'b0, '0);
    mc_en = 1'b1;
  endtask
  task automatic test_wr_prio();
    drive(0, 1'b1, 1'b1, 64'h40);
    tick();
    n_chk++; if (grant_id !== 2'd0) $display("FAIL prio_setup: got %0d exp 0", grant_id); else n_pass++;
    tick();
    drive(0, 1'b1, 1'b0, '0);
    drive(1, 1'b0, 1'b1, 64'h41);
    drive(3, 1'b1, 1'b1, 64'h43);
    tick();
    n_chk++; if (grant_id !== 2'(EXP_PRIO)) $display("FAIL prio_grant: got %0d exp %0d", grant_id, EXP_PRIO); else n_pass++;
    tick();
    drive(1, 1'b0, 1'b0, '0);
    drive(3, 1'b1, 1'b0, '0);
  endtask
  initial begin
    rst = 1'b1;
    mc_en = 1'b1;
    bus.in_frame_data = '0;
    bus.in_frame_valid = '0;
    bus.axi_frame_ready = 1'b0;
    bus.array_rdata = '0;
    bus.array_rvalid = 1'b0;
    test_reset();
    test_rr_writes();
    test_hold_stall();
    test_read_order();
    test_full_mask();
    test_orphan();
    test_reset_mid_hold();
    test_mc_en();
    test_wr_prio();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
